// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw pins in, debounced level and event pulses out.
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_hold;
  logic [NUM_BTN-1:0] btn_repeat;

  // The conditioner itself: reads pins, produces clean button events.
  modport master (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_hold,
    output btn_repeat
  );

  // Pin side / event consumer.
  modport slave (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_hold,
    input  btn_repeat
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button front end: 2-flop synchronizer, polarity normalisation, debounce,
// press/release pulses and a long-press hold FSM with auto-repeat.
module btn_conditioner #(
  parameter int unsigned        NUM_BTN         = 4,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 4'b0001,
  parameter int unsigned        DEBOUNCE_CYCLES = 120000,
  parameter int unsigned        HOLD_CYCLES     = 6000000,
  parameter int unsigned        REPEAT_CYCLES   = 1200000
) (
  input logic               CLK,
  input logic               RST_N,
  btn_conditioner_if.master bus
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  // Hold fires when the counter, cleared on the press cycle, would reach HOLD_CYCLES-1.
  localparam int unsigned HoldLast = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0;

  typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

  logic [NUM_BTN-1:0] level_vec, press_vec, release_vec, hold_vec, repeat_vec;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic             sync1_q, sync2_q, s;
    logic             level_q, level_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             rise, fall;
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    logic             repeat_d;
    logic             press_q, release_q, hold_q, repeat_q;

    // Two-flop synchronizer, reset to the idle pin level so reset release is quiet.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync1_q <= ACTIVE_LOW_MASK[i];
        sync2_q <= ACTIVE_LOW_MASK[i];
      end else begin
        sync1_q <= bus.btn_raw[i];
        sync2_q <= sync1_q;
      end
    end

    assign s = sync2_q ^ ACTIVE_LOW_MASK[i];

    // Debounce: count consecutive mismatch cycles, any matching cycle restarts the count.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (s != level_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Hold FSM next state; a level fall overrides any hold or repeat event.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      repeat_d   = 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            hold_cnt_d = '0;
            if (HOLD_CYCLES == 1) begin
              state_d   = StHeld;
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              state_d = StPressed;
            end
          end
        end
        StPressed: begin
          if (fall) begin
            state_d = StIdle;
          end else if (hold_cnt_q == HoldW'(HoldLast)) begin
            state_d   = StHeld;
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (fall) begin
            state_d = StIdle;
          end else if (rep_cnt_q == RepW'(REPEAT_CYCLES - 1)) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        level_q    <= 1'b0;
        db_cnt_q   <= '0;
        state_q    <= StIdle;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        level_q    <= level_d;
        db_cnt_q   <= db_cnt_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        press_q    <= rise;
        release_q  <= fall;
        hold_q     <= (state_d == StHeld);
        repeat_q   <= repeat_d;
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;
    assign hold_vec[i]    = hold_q;
    assign repeat_vec[i]  = repeat_q;
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.btn_hold    = hold_vec;
  assign bus.btn_repeat  = repeat_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed and random button activity against a window-based
// behavioural model of debounce, press/release, hold and repeat.
module tb_btn_conditioner;

  localparam int unsigned NB   = 4;
  localparam logic [3:0]  MASK = 4'b0001;
  localparam int          DEB  = 8;
  localparam int          HOLD = 20;
  localparam int          REP  = 5;

  logic clk;
  logic rst_n;

  btn_conditioner_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN        (NB),
    .ACTIVE_LOW_MASK(MASK),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: edges since reset release, raw pin history per edge.
  int          n;
  logic [NB-1:0] raw_hist [0:8191];
  logic [NB-1:0] pressed;
  logic [NB-1:0] m_level, m_press, m_rel, m_hold, m_rep;
  int          m_last_tog [NB];
  int          m_press_edge [NB];
  int          cnt_press [NB];
  int          cnt_rep [NB];
  int          first_p3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic drive();
    bus.btn_raw = pressed ^ MASK;
  endtask

  task automatic model_reset();
    n = 0;
    m_level = '0; m_press = '0; m_rel = '0; m_hold = '0; m_rep = '0;
    for (int ch = 0; ch < NB; ch++) begin
      m_last_tog[ch]   = 0;
      m_press_edge[ch] = 0;
    end
  endtask

  // Active-high pressed value seen by the debouncer at edge e (two-edge pipeline).
  function automatic logic s_at(int e, int ch);
    if (e < 3) return 1'b0;
    return raw_hist[e-2][ch] ^ MASK[ch];
  endfunction

  // Level flips once the last DEB debouncer samples, all since the previous flip,
  // disagree with it; hold/repeat follow from elapsed time since the press.
  task automatic model_step();
    for (int ch = 0; ch < NB; ch++) begin
      logic old_lvl;
      logic all_diff;
      old_lvl = m_level[ch];
      if (n - m_last_tog[ch] >= DEB) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (s_at(n - k, ch) == old_lvl) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_level[ch]    = ~old_lvl;
          m_last_tog[ch] = n;
        end
      end
      m_press[ch] = m_level[ch] & ~old_lvl;
      m_rel[ch]   = ~m_level[ch] & old_lvl;
      if (m_press[ch]) m_press_edge[ch] = n;
      m_hold[ch] = m_level[ch] && (n - m_press_edge[ch] >= HOLD - 1);
      m_rep[ch]  = m_hold[ch] && (((n - m_press_edge[ch] - (HOLD - 1)) % REP) == 0);
    end
  endtask

  // Advance one clock, update the model and compare all outputs.
  task automatic tick();
    @(negedge clk);
    n++;
    if (n < 8192) raw_hist[n] = bus.btn_raw;
    model_step();
    check("level",   32'(bus.btn_level),   32'(m_level));
    check("press",   32'(bus.btn_press),   32'(m_press));
    check("release", 32'(bus.btn_release), 32'(m_rel));
    check("hold",    32'(bus.btn_hold),    32'(m_hold));
    check("repeat",  32'(bus.btn_repeat),  32'(m_rep));
    for (int ch = 0; ch < NB; ch++) begin
      cnt_press[ch] += int'(bus.btn_press[ch]);
      cnt_rep[ch]   += int'(bus.btn_repeat[ch]);
    end
    if (bus.btn_press[3] && first_p3 < 0) first_p3 = n;
  endtask

  task automatic ticks(input int cycles);
    for (int c = 0; c < cycles; c++) tick();
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < NB; ch++) begin
      cnt_press[ch] = 0;
      cnt_rep[ch]   = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(bus.btn_level),   32'd0);
    check({tag, "_press"},   32'(bus.btn_press),   32'd0);
    check({tag, "_release"}, 32'(bus.btn_release), 32'd0);
    check({tag, "_hold"},    32'(bus.btn_hold),    32'd0);
    check({tag, "_repeat"},  32'(bus.btn_repeat),  32'd0);
  endtask

  int dur [NB];
  int r;

  initial begin
    first_p3 = -1;
    pressed  = '0;
    drive();
    rst_n = 1'b0;
    model_reset();
    clear_counts();
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    #2 rst_n = 1'b1;

    // Quiet after reset release, including the active-low channel held idle-high.
    ticks(20);

    // Clean press and release on channel 1.
    pressed[1] = 1'b1; drive(); ticks(30);
    pressed[1] = 1'b0; drive(); ticks(30);

    // Bounce on channel 2: toggles every 3 cycles, then settles pressed.
    clear_counts();
    for (int t = 0; t < 40; t++) begin
      if (t % 3 == 0) pressed[2] = ~pressed[2];
      drive();
      tick();
    end
    check("bounce_quiet", 32'(cnt_press[2]), 32'd0);
    pressed[2] = 1'b1; drive(); ticks(30);
    check("bounce_press_cnt", 32'(cnt_press[2]), 32'd1);
    pressed[2] = 1'b0; drive(); ticks(20);

    // Active-low channel 0.
    pressed[0] = 1'b1; drive(); ticks(30);
    pressed[0] = 1'b0; drive(); ticks(20);

    // Long hold on channel 3: level high 60 cycles gives 9 repeats.
    clear_counts();
    pressed[3] = 1'b1; drive(); ticks(60);
    pressed[3] = 1'b0; drive(); ticks(20);
    check("hold_press_cnt", 32'(cnt_press[3]), 32'd1);
    check("hold_rep_cnt",   32'(cnt_rep[3]),   32'd9);

    // Glitch rejection: 7 cycles rejected, 8 accepted.
    clear_counts();
    pressed[1] = 1'b1; drive(); ticks(7);
    pressed[1] = 1'b0; drive(); ticks(20);
    check("glitch7_press_cnt", 32'(cnt_press[1]), 32'd0);
    pressed[1] = 1'b1; drive(); ticks(8);
    pressed[1] = 1'b0; drive(); ticks(20);
    check("glitch8_press_cnt", 32'(cnt_press[1]), 32'd1);

    // Random activity on all channels with a mix of glitch, medium and long durations.
    for (int ch = 0; ch < NB; ch++) dur[ch] = 1;
    repeat (3000) begin
      for (int ch = 0; ch < NB; ch++) begin
        dur[ch]--;
        if (dur[ch] == 0) begin
          pressed[ch] = ~pressed[ch];
          r = int'($urandom_range(0, 9));
          if (r < 5)      dur[ch] = int'($urandom_range(1, 9));
          else if (r < 8) dur[ch] = int'($urandom_range(10, 40));
          else            dur[ch] = int'($urandom_range(40, 80));
        end
      end
      drive();
      tick();
    end
    pressed = '0; drive(); ticks(40);

    // Async reset while channel 3 is held.
    pressed[3] = 1'b1; drive();
    for (int c = 0; c < 200 && !m_hold[3]; c++) tick();
    ticks(3);
    check("held_before_rst", 32'(bus.btn_hold[3]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("in_rst");
    #2 rst_n = 1'b1;
    first_p3 = -1;
    ticks(60);
    check("rst_press_edge", 32'(first_p3), 32'(DEB + 2));
    pressed[3] = 1'b0; drive(); ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
